// File: rtl/i2s_pcm_source.sv
// i2s_pcm_source
// I2S master receiver feeding a PCM consumer (the MFCC core). It generates
// SCK and WS for an I2S MEMS microphone, deserialises one channel slot MSB
// first, truncates it to SAMPLE_WIDTH bits and presents it with a one-cycle
// ready strobe. After enable, WARMUP_FRAMES frames are discarded while the
// microphone settles.
//
// Ports:
//   clk          system clock (the only clock)
//   rst_n        asynchronous active-low reset
//   enable_i     level enable; low forces IDLE in the next cycle
//   i2s_sck_o    bit clock to the microphone
//   i2s_ws_o     word select to the microphone (low = left slot)
//   i2s_sd_i     serial data from the microphone, changes after SCK falls
//   pcm_o        last captured sample, two's complement, held between updates
//   pcm_ready_o  one-cycle strobe, pcm_o valid in the same cycle
//   warm_o       high while in RUN
module i2s_pcm_source #(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int SLOT_WIDTH    = 32,
    parameter int SCK_HALF      = 16,
    parameter int CHANNEL       = 0,
    parameter int WARMUP_FRAMES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable_i,
    output logic                           i2s_sck_o,
    output logic                           i2s_ws_o,
    input  logic                           i2s_sd_i,
    output logic signed [SAMPLE_WIDTH-1:0] pcm_o,
    output logic                           pcm_ready_o,
    output logic                           warm_o
);

    localparam int DW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int BW = $clog2(2 * SLOT_WIDTH);
    localparam int FW = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_TC       = DW'(SCK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] WS_LO        = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0] WS_HI        = BW'(2 * SLOT_WIDTH - 2);
    localparam logic [BW-1:0] CAP_BASE     = BW'(CHANNEL * SLOT_WIDTH);
    localparam logic [BW-1:0] CAP_LEN      = BW'(SAMPLE_WIDTH);
    localparam logic [BW-1:0] CAP_LAST_REL = BW'(SAMPLE_WIDTH - 1);
    localparam logic [FW-1:0] WARM_LAST    = FW'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]                  div_cnt;
    logic [BW-1:0]                  bit_cnt;
    logic [BW-1:0]                  bit_nxt;
    logic [BW-1:0]                  cap_rel;
    logic [FW-1:0]                  frame_cnt;
    logic signed [SAMPLE_WIDTH-1:0] shreg;
    logic                           lsb_pend;

    logic div_tc;
    logic sck_rise;
    logic sck_fall;
    logic frame_wrap;
    logic last_warm;
    logic cap_win;
    logic cap_en;
    logic ws_nxt;

    assign div_tc     = (div_cnt == DIV_TC);
    assign sck_rise   = div_tc && !i2s_sck_o;
    assign sck_fall   = div_tc && i2s_sck_o;
    assign frame_wrap = sck_fall && (bit_cnt == BIT_LAST);
    assign last_warm  = (frame_cnt == WARM_LAST);
    assign bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);

    // Offset from the start of the captured slot; wraps to a large value
    // before the slot, so a single compare covers both window bounds.
    assign cap_rel = bit_cnt - CAP_BASE;
    assign cap_win = (cap_rel < CAP_LEN);
    // Shifting in the last warm-up frame is harmless: no strobe can come
    // from it, and the register is refilled before the first RUN sample.
    assign cap_en  = cap_win && ((state_q == RUN) || ((state_q == WARMUP) && last_warm));

    // WS is set from the bit index that the falling edge is about to load,
    // so it leads each slot by one SCK.
    assign ws_nxt = (bit_nxt >= WS_LO) && (bit_nxt <= WS_HI);

    assign warm_o = (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = (WARMUP_FRAMES == 0) ? RUN : WARMUP;
                end
            end
            WARMUP: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (frame_wrap && last_warm) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            shreg       <= '0;
            lsb_pend    <= 1'b0;
            i2s_sck_o   <= 1'b0;
            i2s_ws_o    <= 1'b0;
            pcm_o       <= '0;
            pcm_ready_o <= 1'b0;
        end else if (state_q == IDLE || !enable_i) begin
            // Idle or being disabled: everything restarts from a clean frame,
            // a half-captured sample is dropped and pcm_o keeps its value.
            div_cnt     <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            shreg       <= '0;
            lsb_pend    <= 1'b0;
            i2s_sck_o   <= 1'b0;
            i2s_ws_o    <= 1'b0;
            pcm_ready_o <= 1'b0;
        end else begin
            pcm_ready_o <= lsb_pend;
            lsb_pend    <= 1'b0;
            if (lsb_pend) begin
                pcm_o <= shreg;
            end

            if (div_tc) begin
                div_cnt   <= '0;
                i2s_sck_o <= ~i2s_sck_o;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            if (sck_rise && cap_en) begin
                shreg <= {shreg[SAMPLE_WIDTH-2:0], i2s_sd_i};
                // RUN is only entered at a frame wrap, so any LSB seen in RUN
                // belongs to a slot that started in RUN.
                if ((cap_rel == CAP_LAST_REL) && (state_q == RUN)) begin
                    lsb_pend <= 1'b1;
                end
            end

            if (sck_fall) begin
                bit_cnt  <= bit_nxt;
                i2s_ws_o <= ws_nxt;
                if (frame_wrap && (state_q == WARMUP)) begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_pcm_source.sv
// Directed bench for i2s_pcm_source: two instances (left and right channel,
// two warm-up frames) share one microphone model and are checked at
// hand-computed cycle offsets from the enable edge.
module tb_i2s_pcm_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sd;
    logic        sck0, ws0, ready0, warm0;
    logic        sck1, ws1, ready1, warm1;
    logic [15:0] pcm0, pcm1;

    int ntests = 0;
    int nfail  = 0;
    int now_t  = 0;
    int cnt0   = 0;
    int cnt1   = 0;
    int left_leak = 0;
    int idx    = 0;
    logic [63:0] frame_word = {32'h8001_ABCD, 32'h1234_5678};
    logic ws_prev  = 1'b0;
    logic sck_prev = 1'b0;

    always #5 clk = ~clk;

    i2s_pcm_source #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .SCK_HALF(16),
                     .CHANNEL(0), .WARMUP_FRAMES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .i2s_sck_o(sck0), .i2s_ws_o(ws0), .i2s_sd_i(sd),
        .pcm_o(pcm0), .pcm_ready_o(ready0), .warm_o(warm0));

    i2s_pcm_source #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .SCK_HALF(16),
                     .CHANNEL(1), .WARMUP_FRAMES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .i2s_sck_o(sck1), .i2s_ws_o(ws1), .i2s_sd_i(sd),
        .pcm_o(pcm1), .pcm_ready_o(ready1), .warm_o(warm1));

    // Microphone: bit n of the 64-bit frame is presented during SCK period n,
    // advancing after each falling edge.
    always @(negedge sck0) idx = (idx == 63) ? 0 : idx + 1;
    assign sd = frame_word[63 - idx];

    always @(negedge clk) begin
        if (ready0) cnt0++;
        if (ready1) cnt1++;
        if (ready1 && pcm1 == 16'h8001) left_leak++;
        if (rst_n && enable && ws0 !== ws_prev) begin
            ntests++;
            assert (sck_prev === 1'b1 && sck0 === 1'b0)
            else begin
                nfail++;
                $error("FAIL ws_on_sck_fall: sck %b->%b, required 1->0", sck_prev, sck0);
            end
        end
        ws_prev  = ws0;
        sck_prev = sck0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step_to(input int target);
        repeat (target - now_t) @(posedge clk);
        now_t = target;
        #1;
    endtask

    task automatic start_enable();
        idx = 0;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        now_t = 0;
        #1;
    endtask

    initial begin
        int bad;
        int sck_edges;
        logic last_sck;

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sck", sck0, 0);
        chk("rst_ws", ws0, 0);
        chk("rst_pcm", pcm0, 0);
        chk("rst_ready", ready0, 0);
        chk("rst_warm", warm0, 0);

        rst_n = 1'b1;
        bad = 0;
        sck_edges = 0;
        last_sck = sck0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sck0 !== last_sck) sck_edges++;
            last_sck = sck0;
            if ({sck0, ws0, ready0, warm0, sck1, ws1, ready1, warm1} !== 8'h00) bad++;
            if (pcm0 !== 16'h0 || pcm1 !== 16'h0) bad++;
        end
        chk("idle_outputs", bad, 0);
        chk("idle_sck_edges", sck_edges, 0);

        // First enable: t = 0 is the edge that samples enable high.
        start_enable();
        step_to(15);   chk("sck_t15", sck0, 0);
        step_to(16);   chk("sck_rise_t16", sck0, 1);
        step_to(31);   chk("sck_t31", sck0, 1);
        step_to(32);   chk("sck_fall_t32", sck0, 0);
        step_to(48);   chk("sck_rise_t48", sck0, 1);
        step_to(991);  chk("ws_t991", ws0, 0);
        step_to(992);  chk("ws_rise_t992", ws0, 1);
        step_to(2015); chk("ws_t2015", ws0, 1);
        step_to(2016); chk("ws_fall_t2016", ws0, 0);
        step_to(2545); chk("no_strobe_warmup", ready0, 0);
        step_to(4095); chk("warm_t4095", warm0, 0);
        step_to(4096); chk("warm0_t4096", warm0, 1);
                       chk("warm1_t4096", warm1, 1);
        step_to(4592); chk("ready0_t4592", ready0, 0);
        step_to(4593); chk("ready0_t4593", ready0, 1);
                       chk("pcm0_t4593", pcm0, 32'h8001);
        step_to(4594); chk("ready0_t4594", ready0, 0);
        step_to(5000); chk("pcm0_held", pcm0, 32'h8001);
        step_to(5616); chk("ready1_t5616", ready1, 0);
        step_to(5617); chk("ready1_t5617", ready1, 1);
                       chk("pcm1_t5617", pcm1, 32'h1234);
        step_to(6641); chk("ready0_t6641", ready0, 1);
                       chk("pcm0_t6641", pcm0, 32'h8001);
        step_to(7665); chk("ready1_t7665", ready1, 1);

        // Drop enable so it is sampled at frame-relative 300 (left capture).
        step_to(8491); chk("cnt0_before_drop", cnt0, 2);
                       chk("cnt1_before_drop", cnt1, 2);
        enable = 1'b0;
        step_to(8492); chk("drop_sck", sck0, 0);
                       chk("drop_ws", ws0, 0);
                       chk("drop_warm", warm0, 0);
                       chk("drop_pcm0_kept", pcm0, 32'h8001);
                       chk("drop_pcm1_kept", pcm1, 32'h1234);
        step_to(9000); chk("drop_no_strobe", cnt0, 2);

        // Re-enable: warm-up must run again from the start.
        start_enable();
        step_to(2545); chk("re_no_strobe", ready0, 0);
        step_to(4095); chk("re_warm_t4095", warm0, 0);
        step_to(4096); chk("re_warm_t4096", warm0, 1);

        // Reset at frame-relative 490 in RUN, just before the strobe.
        step_to(4586);
        rst_n = 1'b0;
        #1;
        chk("arst_sck", sck0, 0);
        chk("arst_ws", ws0, 0);
        chk("arst_pcm0", pcm0, 0);
        chk("arst_pcm1", pcm1, 0);
        chk("arst_ready", ready0, 0);
        chk("arst_warm", warm0, 0);
        step_to(4594); chk("arst_no_ready", ready0, 0);
                       chk("arst_cnt0", cnt0, 2);
        chk("left_never_on_ch1", left_leak, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/i2s_pcm_source.md
# i2s_pcm_source

I2S master receiver that produces the PCM sample stream consumed by the MFCC core's `pcm_in` / `pcm_ready_i` input. It generates the bit clock and word select for an I2S MEMS microphone. It deserialises the selected channel, MSB first, and presents each truncated signed sample with a one-cycle ready strobe. With `clk` = 25 MHz and default parameters the frame rate is 25e6 / 2048 ≈ 12207 Hz, which is the MFCC core's `SAMPLE_RATE`.

## Interface
- `SAMPLE_WIDTH`, 16: output sample width; top bits of each slot.
- `SLOT_WIDTH`, 32: SCK periods per channel slot; must be greater than `SAMPLE_WIDTH`.
- `SCK_HALF`, 16: `clk` cycles per SCK half period; minimum 2.
- `CHANNEL`, 0: captured slot; 0 = left (WS low), 1 = right (WS high).
- `WARMUP_FRAMES`, 1024: frames discarded after enable, for microphone start-up; 0 disables warm-up.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable_i`  in  1  level; high runs the interface, low forces idle.
- `i2s_sck_o`  out  1  bit clock to the microphone.
- `i2s_ws_o`  out  1  word select to the microphone.
- `i2s_sd_i`  in  1  serial data from the microphone; it changes after SCK falling edges.
- `pcm_o`  out  SAMPLE_WIDTH  last captured sample, two's complement; held between updates.
- `pcm_ready_o`  out  1  one-cycle strobe; `pcm_o` is valid in the same cycle.
- `warm_o`  out  1  high while in RUN.

## Operation
- States: IDLE, WARMUP, RUN.
  - IDLE → WARMUP when `enable_i`=1 and `WARMUP_FRAMES`>0.
  - IDLE → RUN directly when `WARMUP_FRAMES`=0.
  - WARMUP → RUN at the frame wrap that completes `WARMUP_FRAMES` frames.
  - Any state → IDLE in the cycle after `enable_i` is sampled low.
- Entry to IDLE clears `div_cnt`, `bit_cnt`, the frame counter and the shift register.
- Entry to IDLE drives `i2s_sck_o`=0 and `i2s_ws_o`=0.
- Entry to IDLE holds `pcm_o` unchanged.
- `div_cnt` counts 0..`SCK_HALF`-1. At terminal count `i2s_sck_o` toggles.
- `bit_cnt` counts 0..2·`SLOT_WIDTH`-1 and advances on every SCK falling edge.
  - A wrap from 2·`SLOT_WIDTH`-1 to 0 is a frame boundary.
- `i2s_ws_o` is registered high for `bit_cnt` in [`SLOT_WIDTH`-1, 2·`SLOT_WIDTH`-2] and low otherwise. WS therefore leads each slot by one SCK (standard I2S).
- Capture: on the `clk` edge where `i2s_sck_o` goes 0→1, `i2s_sd_i` shifts into the shift register (MSB first) when both hold:
  - `bit_cnt` - `CHANNEL`·`SLOT_WIDTH` is in [0, `SAMPLE_WIDTH`-1];
  - and the state is RUN, or the state is WARMUP and this is the final warm-up frame.
- Bits beyond `SAMPLE_WIDTH` in a slot are ignored; this is truncation with no rounding.
- After the LSB capture: `pcm_o` ← shift register and `pcm_ready_o`=1 on the next `clk` edge, for one cycle only.
- Only slots that start while in RUN produce a strobe. A partially captured slot interrupted by disable produces no strobe.
- There is no backpressure: the consumer must accept one sample per frame. The MFCC pre-emphasis stage always does.

## Timing
- Reset values:
  - `i2s_sck_o`=0, `i2s_ws_o`=0, `pcm_o`=0, `pcm_ready_o`=0, `warm_o`=0;
  - state IDLE, all counters 0.
- Reset is asynchronous assert and takes effect immediately mid-frame. On release the block waits in IDLE until `enable_i`=1.
- The first SCK rising edge occurs `SCK_HALF` cycles after leaving IDLE.
- SCK period is 2·`SCK_HALF` cycles. Frame length is 4·`SLOT_WIDTH`·`SCK_HALF` cycles; 2048 with defaults.
- With frame start at t=0 (`bit_cnt` becomes 0), the rising edge of SCK period n is at t = n·2·`SCK_HALF` + `SCK_HALF`.
- Defaults, `CHANNEL`=0:
  - LSB captured at t = 15·32 + 16 = 496;
  - `pcm_ready_o` high at t = 497.
- Defaults, `CHANNEL`=1: LSB captured at t = 47·32 + 16 = 1520; strobe at 1521.
- Consecutive strobes are exactly one frame apart; jitter is 0.
- `warm_o` rises in the same cycle the state enters RUN.
- `enable_i` toggling within the same cycle as a frame wrap: the disable wins and no state advance occurs.

## Test plan
- Reset release, `enable_i`=0 for 100 cycles:
  - all outputs stay 0;
  - no SCK edges.
- `WARMUP_FRAMES`=2, `CHANNEL`=0. Microphone model sends left 0x8001_xxxx and right 0x1234_xxxx every frame:
  - `warm_o` rises at cycle 4096 after enable;
  - first strobe at frame-relative 497 with `pcm_o`=0x8001;
  - strobes then repeat every 2048 cycles.
- Same stimulus with `CHANNEL`=1:
  - `pcm_o`=0x1234 with strobe at frame-relative 1521;
  - the left data never appears.
- Protocol check, defaults:
  - SCK period 32 cycles at 50% duty;
  - WS toggles only on SCK falling edges, at `bit_cnt` 31 and 63;
  - SD is sampled only at rising edges.
- `enable_i` dropped at frame-relative t=300, during left-slot capture:
  - no strobe;
  - SCK and WS are 0 the next cycle;
  - `pcm_o` keeps the previous sample;
  - re-enable restarts warm-up.
- `rst_n` asserted at t=490 in RUN:
  - outputs are 0 immediately;
  - `pcm_ready_o` does not fire at 497.
